// File: rtl/rq_arb_pkg.sv
// Shared types and constants for the RQ arbiter: FSM encoding, index width,
// stall counter width and a modulo helper for round-robin rotation.
package rq_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int IDX_W    = 2;
  localparam int STALL_CW = 11;

  // Reduce v modulo n, valid for v < 2*n (one rotation step past the end).
  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v, input int unsigned n);
    int unsigned w;
    w = (v >= n) ? v - n : v;
    return IDX_W'(w);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester after
// last_idx (modulo NUM_REQ) whose request bit is set.
module rr_pick
  import rq_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  // Candidate gi is the requester gi+1 places after last_idx.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic sel;

    assign cand_idx[gi] = wrap_idx(32'(last_idx) + 32'(gi + 1), NUM_REQ);

    always_comb begin
      sel = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (cand_idx[gi] == IDX_W'(j)) begin
          sel = req[j];
        end
      end
    end

    assign cand_req[gi] = sel;
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        hit = 1'b1;
        idx = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/rq_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe RQ AXI-Stream port
// among NUM_REQ requesters, with a sticky mid-packet stall watchdog.
module rq_arbiter
  import rq_arb_pkg::*;
#(
  parameter int NUM_REQ             = 2,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int STALL_LIMIT         = 1024
) (
  input  logic                                   user_clk,
  input  logic                                   reset,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        req_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]          req_tkeep,
  input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
  input  logic [NUM_REQ-1:0]                     req_tlast,
  input  logic [NUM_REQ-1:0]                     req_tvalid,
  output logic [NUM_REQ-1:0]                     req_tready,
  output logic [C_DATA_WIDTH-1:0]                s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]                  s_axis_rq_tkeep,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]         s_axis_rq_tuser,
  output logic                                   s_axis_rq_tlast,
  output logic                                   s_axis_rq_tvalid,
  input  logic                                   s_axis_rq_tready,
  output logic [NUM_REQ-1:0]                     grant,
  output logic                                   stall_err,
  output logic [1:0]                             stall_id
);

  localparam logic [STALL_CW-1:0] LIMIT_C  = STALL_CW'(STALL_LIMIT);
  localparam logic [STALL_CW-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]    LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    gnt_idx_q;
  logic [IDX_W-1:0]    last_idx_q;
  logic [IDX_W-1:0]    stall_id_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  grant_d;
  logic [STALL_CW-1:0] stall_cnt_q;
  logic [STALL_CW-1:0] stall_cnt_d;
  logic                stall_err_q;
  logic                stall_set;

  logic                busy;
  logic                owner_valid;
  logic                owner_accept;
  logic                eop;
  logic [NUM_REQ-1:0]  pick_req;
  logic [IDX_W-1:0]    pick_last;
  logic                pick_hit;
  logic [IDX_W-1:0]    pick_idx;

  assign busy = (state_q == ST_BUSY);

  // grant_q is zero in IDLE, so masking it only removes the departing owner
  // at end of packet; searching from gnt_idx_q keeps rotation fair.
  assign pick_req  = req_tvalid & ~grant_q;
  assign pick_last = busy ? gnt_idx_q : last_idx_q;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req     (pick_req),
    .last_idx(pick_last),
    .hit     (pick_hit),
    .idx     (pick_idx)
  );

  always_comb begin
    grant_d = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_idx == IDX_W'(j)) begin
        grant_d[j] = 1'b1;
      end
    end
  end

  always_comb begin
    s_axis_rq_tdata = '0;
    s_axis_rq_tkeep = '0;
    s_axis_rq_tuser = '0;
    s_axis_rq_tlast = 1'b0;
    req_tready      = '0;
    owner_valid     = 1'b0;
    if (busy) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (gnt_idx_q == IDX_W'(j)) begin
          s_axis_rq_tdata = req_tdata[j*C_DATA_WIDTH +: C_DATA_WIDTH];
          s_axis_rq_tkeep = req_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
          s_axis_rq_tuser = req_tuser[j*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
          s_axis_rq_tlast = req_tlast[j];
          owner_valid     = req_tvalid[j];
          req_tready[j]   = s_axis_rq_tready;
        end
      end
    end
  end

  assign s_axis_rq_tvalid = owner_valid;
  assign owner_accept     = owner_valid & s_axis_rq_tready;
  assign eop              = owner_accept & s_axis_rq_tlast;

  // Backpressure (valid held, ready low) neither counts nor clears.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!busy || owner_accept) begin
      stall_cnt_d = '0;
    end else if (!owner_valid && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign stall_set = busy & ~stall_err_q & (stall_cnt_d >= LIMIT_C);

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_idx_q   <= '0;
      last_idx_q  <= LAST_RST;
      grant_q     <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      stall_id_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_set) begin
        stall_err_q <= 1'b1;
        stall_id_q  <= gnt_idx_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_hit) begin
            state_q   <= ST_BUSY;
            gnt_idx_q <= pick_idx;
            grant_q   <= grant_d;
          end
        end
        ST_BUSY: begin
          if (eop) begin
            last_idx_q <= gnt_idx_q;
            if (pick_hit) begin
              gnt_idx_q <= pick_idx;
              grant_q   <= grant_d;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign stall_err = stall_err_q;
  assign stall_id  = stall_id_q;

endmodule

// File: tb/tb_rq_arbiter.sv
// Directed bench for rq_arbiter: reset, single-requester packets, alternation,
// mid-packet contention under backpressure, stall watchdog and mid-packet reset.
module tb_rq_arbiter;

  localparam int NR = 2;
  localparam int DW = 128;
  localparam int KW = DW / 32;
  localparam int UW = 62;
  localparam int SL = 20;

  logic             user_clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    d [NR];
  logic [KW-1:0]    k [NR];
  logic [UW-1:0]    u [NR];
  logic [NR-1:0]    l;
  logic [NR-1:0]    v;
  logic [NR-1:0]    req_tready;
  logic [DW-1:0]    s_tdata;
  logic [KW-1:0]    s_tkeep;
  logic [UW-1:0]    s_tuser;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [NR-1:0]    grant;
  logic             stall_err;
  logic [1:0]       stall_id;
  logic [NR*DW-1:0] req_tdata;
  logic [NR*KW-1:0] req_tkeep;
  logic [NR*UW-1:0] req_tuser;

  int n_total = 0;
  int n_pass  = 0;

  assign req_tdata = {d[1], d[0]};
  assign req_tkeep = {k[1], k[0]};
  assign req_tuser = {u[1], u[0]};

  always #5 user_clk = ~user_clk;

  rq_arbiter #(
    .NUM_REQ            (NR),
    .C_DATA_WIDTH       (DW),
    .KEEP_WIDTH         (KW),
    .AXI4_RQ_TUSER_WIDTH(UW),
    .STALL_LIMIT        (SL)
  ) dut (
    .user_clk        (user_clk),
    .reset           (reset),
    .req_tdata       (req_tdata),
    .req_tkeep       (req_tkeep),
    .req_tuser       (req_tuser),
    .req_tlast       (l),
    .req_tvalid      (v),
    .req_tready      (req_tready),
    .s_axis_rq_tdata (s_tdata),
    .s_axis_rq_tkeep (s_tkeep),
    .s_axis_rq_tuser (s_tuser),
    .s_axis_rq_tlast (s_tlast),
    .s_axis_rq_tvalid(s_tvalid),
    .s_axis_rq_tready(s_tready),
    .grant           (grant),
    .stall_err       (stall_err),
    .stall_id        (stall_id)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  function automatic logic [127:0] tag(input int r, input int p, input int b);
    return {32'hC0DE_0000 | 32'((r << 8) | (p << 4) | b), 32'(b * 3 + r),
            64'h0123_4567_89AB_CDEF ^ 64'(p)};
  endfunction

  function automatic logic [1:0] oh(input int r);
    return 2'(1 << r);
  endfunction

  initial begin
    int own;
    int oth;
    int bt;
    logic trv;

    reset    = 1'b1;
    v        = '0;
    l        = '0;
    s_tready = 1'b1;
    d[0] = '0; d[1] = '0;
    k[0] = 4'hF; k[1] = 4'h7;
    u[0] = 62'h0AAA_5555_1234_0001;
    u[1] = 62'h1555_AAAA_4321_0002;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_stall_id", stall_id, 0);
    check("rst_tready", req_tready, 0);
    check("rst_tvalid", s_tvalid, 0);
    step();

    // Single 3-beat packet from requester 0.
    v[0] = 1'b1; d[0] = tag(0, 0, 0); l[0] = 1'b0;
    #1;
    check("t1_dec_grant", grant, 0);
    check("t1_dec_tvalid", s_tvalid, 0);
    step();
    for (int b = 0; b < 3; b++) begin
      d[0] = tag(0, 0, b); l[0] = (b == 2);
      #1;
      check("t1_grant", grant, 2'b01);
      check("t1_tvalid", s_tvalid, 1);
      check("t1_tdata", s_tdata, tag(0, 0, b));
      check("t1_tlast", s_tlast, (b == 2));
      check("t1_tready", req_tready, 2'b01);
      if (b == 0) begin
        check("t1_tkeep", s_tkeep, 4'hF);
        check("t1_tuser", s_tuser, u[0]);
      end
      step();
    end
    $display("pkt owner=0 beats=3");
    v[0] = 1'b0;
    #1;
    check("t1_idle_grant", grant, 0);
    check("t1_idle_tvalid", s_tvalid, 0);
    step();

    // Both valid, 2-beat packets: owners 1,0,1,0 with no bubble.
    v = 2'b11;
    d[0] = tag(0, 1, 0); l[0] = 1'b0;
    d[1] = tag(1, 0, 0); l[1] = 1'b0;
    #1;
    check("t2_dec_tvalid", s_tvalid, 0);
    step();
    for (int p = 0; p < 4; p++) begin
      own = (p % 2 == 0) ? 1 : 0;
      oth = 1 - own;
      if (p == 3) v[oth] = 1'b0;
      else begin
        d[oth] = tag(oth, p + 1, 0); l[oth] = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
        d[own] = tag(own, p, b); l[own] = (b == 1);
        #1;
        check("t2_grant", grant, oh(own));
        check("t2_tready", req_tready, oh(own));
        check("t2_tdata", s_tdata, tag(own, p, b));
        check("t2_tlast", s_tlast, (b == 1));
        step();
      end
      $display("pkt owner=%0d beats=2", own);
    end
    v = '0;
    #1;
    check("t2_idle_grant", grant, 0);
    step();

    // Requester 1 arrives during requester 0's packet; ready toggles.
    v[0] = 1'b1; d[0] = tag(0, 2, 0); l[0] = 1'b0;
    #1;
    step();
    v[1] = 1'b1; d[1] = tag(1, 4, 0); l[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      trv = (c % 2 == 0);
      bt = c / 2;
      s_tready = trv;
      d[0] = tag(0, 2, bt); l[0] = (bt == 3);
      #1;
      check("t3_grant", grant, 2'b01);
      check("t3_tvalid", s_tvalid, 1);
      check("t3_tready", req_tready, trv ? 2'b01 : 2'b00);
      check("t3_tdata", s_tdata, tag(0, 2, bt));
      step();
    end
    $display("pkt owner=0 beats=4");
    v[0] = 1'b0; s_tready = 1'b1;
    #1;
    check("t3_handoff_grant", grant, 2'b10);
    check("t3_handoff_tdata", s_tdata, tag(1, 4, 0));
    check("t3_handoff_tlast", s_tlast, 1);
    check("t3_handoff_tkeep", s_tkeep, 4'h7);
    check("t3_handoff_tuser", s_tuser, u[1]);
    step();
    $display("pkt owner=1 beats=1");
    v[1] = 1'b0;
    #1;
    check("t3_idle_grant", grant, 0);
    step();

    // Owner 1 stalls mid-packet for exactly SL cycles.
    v[1] = 1'b1; d[1] = tag(1, 5, 0); l[1] = 1'b0;
    #1;
    step();
    check("t4_grant", grant, 2'b10);
    step();
    v[1] = 1'b0;
    repeat (SL - 1) step();
    check("t4_pre_err", stall_err, 0);
    step();
    check("t4_err", stall_err, 1);
    check("t4_id", stall_id, 1);
    check("t4_grant_kept", grant, 2'b10);
    check("t4_tvalid", s_tvalid, 0);
    v[1] = 1'b1; d[1] = tag(1, 5, 1); l[1] = 1'b1;
    #1;
    check("t4_tail_tdata", s_tdata, tag(1, 5, 1));
    step();
    $display("pkt owner=1 beats=2 stalled");
    v[1] = 1'b0;
    #1;
    check("t4_post_grant", grant, 0);
    check("t4_post_err", stall_err, 1);
    check("t4_post_id", stall_id, 1);
    step();

    // Reset mid-packet; afterwards requester 0 must win a tie.
    v[0] = 1'b1; d[0] = tag(0, 6, 0); l[0] = 1'b1;
    #1;
    step();
    check("t5_r0_grant", grant, 2'b01);
    step();
    $display("pkt owner=0 beats=1");
    v[0] = 1'b0;
    v[1] = 1'b1; d[1] = tag(1, 7, 0); l[1] = 1'b0;
    #1;
    step();
    check("t5_r1_grant", grant, 2'b10);
    step();
    d[1] = tag(1, 7, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    v = 2'b11; d[0] = tag(0, 8, 0); l[0] = 1'b0; d[1] = tag(1, 8, 0); l[1] = 1'b0;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_tvalid", s_tvalid, 0);
    check("t5_rst_tready", req_tready, 0);
    check("t5_rst_err", stall_err, 0);
    step();
    check("t5_after_grant", grant, 2'b01);
    check("t5_after_tdata", s_tdata, tag(0, 8, 0));
    $display("pkt owner=0 after reset");
    v = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
